uart_rx: RTL and testbench

//  UART serial receiver; sits directly downstream of the oversampling tick generator.

---
 rtl/uart_pkg.sv | 14 +
 rtl/uart_rx_if.sv | 22 ++
 rtl/uart_rx_sync_2ff.sv | 23 ++
 rtl/uart_rx.sv | 135 +++++++++++++
 tb/tb_uart_rx.sv | 232 +++++++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receive path.
// The tick-width helper lets the stop counter grow for 1.5 and 2 stop-bit settings.
package uart_pkg;

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} rx_state_t;

    localparam int OVERSAMPLE = 16;
    localparam int MID_TICK   = 7;

    function automatic int tick_width(input int sb_tick);
        return (sb_tick > OVERSAMPLE) ? $clog2(sb_tick) : $clog2(OVERSAMPLE);
    endfunction

endpackage

// File: rtl/uart_rx_if.sv
// Serial-line and parallel-result bundle of the UART receiver.
// The slave side is the receiver; the master side drives the line and tick and consumes the word.
interface uart_rx_if #(
    parameter int DBIT = 8
);
    logic            rx;
    logic            s_tick;
    logic [DBIT-1:0] dout;
    logic            rx_done_tick;
    logic            frame_err;
    logic            parity_err;

    modport master (
        output rx, s_tick,
        input  dout, rx_done_tick, frame_err, parity_err
    );

    modport slave (
        input  rx, s_tick,
        output dout, rx_done_tick, frame_err, parity_err
    );
endinterface

// File: rtl/uart_rx_sync_2ff.sv
// Two-flop synchroniser for asynchronous inputs; the reset value is an input so
// idle-high lines (rx, cts) come out of reset in their inactive state.
module sync_2ff #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] rst_val,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);
    logic [WIDTH-1:0] meta;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            meta <= rst_val;
            q    <= rst_val;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end
endmodule

// File: rtl/uart_rx.sv
// UART receiver: 16x oversampled, mid-bit sampling, LSB-first, optional parity.
// Presents the last word with a one-clock done strobe plus framing/parity flags.
module uart_rx
    import uart_pkg::*;
#(
    parameter int DBIT    = 8,
    parameter int SB_TICK = 16,
    parameter int PAR_EN  = 0,
    parameter int PAR_ODD = 0
) (
    input  logic     clk,
    input  logic     reset_n,
    uart_rx_if.slave bus
);
    localparam int SW = tick_width(SB_TICK);
    localparam int NW = $clog2(DBIT);
    localparam logic [SW-1:0] S_MID  = SW'(MID_TICK);
    localparam logic [SW-1:0] S_LAST = SW'(OVERSAMPLE - 1);
    localparam logic [SW-1:0] S_STOP = SW'(SB_TICK - 1);
    localparam logic [NW-1:0] N_LAST = NW'(DBIT - 1);

    rx_state_t       state, state_next;
    logic [SW-1:0]   s, s_next;
    logic [NW-1:0]   n, n_next;
    logic [DBIT-1:0] b, b_next;
    logic            perr_q, perr_next;
    logic            rx_s;
    logic            frame_end;

    sync_2ff #(.WIDTH(1)) u_sync (
        .clk     (clk),
        .reset_n (reset_n),
        .rst_val (1'b1),
        .d       (bus.rx),
        .q       (rx_s)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state            <= IDLE;
            s                <= '0;
            n                <= '0;
            b                <= '0;
            perr_q           <= 1'b0;
            bus.dout         <= '0;
            bus.rx_done_tick <= 1'b0;
            bus.frame_err    <= 1'b0;
            bus.parity_err   <= 1'b0;
        end else begin
            state            <= state_next;
            s                <= s_next;
            n                <= n_next;
            b                <= b_next;
            perr_q           <= perr_next;
            bus.rx_done_tick <= frame_end;
            if (frame_end) begin
                bus.dout       <= b;
                bus.frame_err  <= ~rx_s;
                bus.parity_err <= perr_q;
            end
        end
    end

    // Start detection in IDLE ignores the tick so a start bit right after the stop sample is not late.
    always_comb begin
        state_next = state;
        s_next     = s;
        n_next     = n;
        b_next     = b;
        perr_next  = perr_q;
        unique case (state)
            IDLE: begin
                if (!rx_s) begin
                    state_next = START;
                    s_next     = '0;
                end
            end
            START: begin
                if (bus.s_tick) begin
                    if (s == S_MID) begin
                        if (!rx_s) begin
                            state_next = DATA;
                            s_next     = '0;
                            n_next     = '0;
                        end else begin
                            state_next = IDLE;
                        end
                    end else begin
                        s_next = s + 1'b1;
                    end
                end
            end
            DATA: begin
                if (bus.s_tick) begin
                    if (s == S_LAST) begin
                        s_next = '0;
                        b_next = {rx_s, b[DBIT-1:1]};
                        if (n == N_LAST)
                            state_next = (PAR_EN != 0) ? PARITY : STOP;
                        else
                            n_next = n + 1'b1;
                    end else begin
                        s_next = s + 1'b1;
                    end
                end
            end
            PARITY: begin
                if (bus.s_tick) begin
                    if (s == S_LAST) begin
                        s_next     = '0;
                        perr_next  = (PAR_ODD != 0) ? ~^{b, rx_s} : ^{b, rx_s};
                        state_next = STOP;
                    end else begin
                        s_next = s + 1'b1;
                    end
                end
            end
            STOP: begin
                if (bus.s_tick) begin
                    if (s == S_STOP) begin
                        s_next     = '0;
                        state_next = IDLE;
                    end else begin
                        s_next = s + 1'b1;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        frame_end = (state == STOP) && bus.s_tick && (s == S_STOP);
    end
endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx: an 8N1 receiver and an 8E2 receiver driven with
// directed and random frames; expectations come from frame-level arithmetic.
module tb_uart_rx;

    typedef struct {
        logic [7:0] data;
        bit         ferr;
        bit         perr;
        longint     start_tick;
    } exp_t;

    localparam int NOM_LAT_N = 8 + 16 * 8 + 16;
    localparam int NOM_LAT_P = 8 + 16 * 9 + 32;

    logic   clk = 1'b0;
    logic   reset_n = 1'b1;
    logic   s_tick = 1'b0;
    logic   rx_n = 1'b1;
    logic   rx_p = 1'b1;
    int     tick_div = 4;
    longint tick_cnt = 0;
    bit     started = 1'b0;
    int     vec_cnt = 0;
    int     fail_cnt = 0;
    exp_t   q_n[$];
    exp_t   q_p[$];
    logic [7:0] last_dout[2];

    uart_rx_if #(.DBIT(8)) bus_n ();
    uart_rx_if #(.DBIT(8)) bus_p ();

    assign bus_n.rx     = rx_n;
    assign bus_n.s_tick = s_tick;
    assign bus_p.rx     = rx_p;
    assign bus_p.s_tick = s_tick;

    uart_rx #(.DBIT(8), .SB_TICK(16), .PAR_EN(0), .PAR_ODD(0)) dut_n (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus_n)
    );

    uart_rx #(.DBIT(8), .SB_TICK(32), .PAR_EN(1), .PAR_ODD(0)) dut_p (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus_p)
    );

    always #5 clk = ~clk;

    initial begin
        forever begin
            repeat (tick_div - 1) @(negedge clk);
            s_tick = 1'b1;
            @(negedge clk);
            s_tick = 1'b0;
        end
    end

    always @(posedge clk) begin
        if (s_tick) tick_cnt <= tick_cnt + 1;
    end

    task automatic check_val(input string name, input longint actual, input longint expected);
        vec_cnt++;
        if (actual != expected) begin
            fail_cnt++;
            $display("[TB] FAIL %s: actual=%0h required=%0h", name, actual, expected);
        end
    endtask

    task automatic wait_ticks(input int n);
        longint target = tick_cnt + n;
        int     budget = n * 8 + 64;
        while (tick_cnt < target) begin
            @(negedge clk);
            budget--;
            if (budget == 0) begin
                vec_cnt++;
                fail_cnt++;
                $display("[TB] FAIL tick_timeout: actual=%0d required=%0d", tick_cnt, target);
                break;
            end
        end
    endtask

    task automatic drive_rx(input int ch, input logic v);
        if (ch == 0) rx_n = v;
        else         rx_p = v;
    endtask

    // One frame: start, 8 data bits LSB first, parity (channel 1 only), stop, then idle gap.
    task automatic applyStimulus(input int ch, input logic [7:0] data, input bit par_bit,
                                 input bit stop_ok, input int gap);
        exp_t e;
        int   sb = (ch == 0) ? 16 : 32;
        e.data       = data;
        e.ferr       = !stop_ok;
        e.perr       = (ch == 1) && ((($countones(data) + int'(par_bit)) % 2) != 0);
        e.start_tick = tick_cnt;
        if (ch == 0) q_n.push_back(e);
        else         q_p.push_back(e);
        drive_rx(ch, 1'b0);
        wait_ticks(16);
        for (int i = 0; i < 8; i++) begin
            drive_rx(ch, data[i]);
            wait_ticks(16);
        end
        if (ch == 1) begin
            drive_rx(ch, par_bit);
            wait_ticks(16);
        end
        if (stop_ok) begin
            drive_rx(ch, 1'b1);
            wait_ticks(sb);
        end else begin
            drive_rx(ch, 1'b0);
            wait_ticks(sb - 4);
            drive_rx(ch, 1'b1);
            wait_ticks(4);
        end
        wait_ticks(gap);
    endtask

    task automatic checkOutput(input int ch, input logic [7:0] dout, input logic ferr, input logic perr);
        exp_t   e;
        bit     have = 1'b0;
        longint lat;
        int     nom = (ch == 0) ? NOM_LAT_N : NOM_LAT_P;
        if (ch == 0 && q_n.size() != 0) begin e = q_n.pop_front(); have = 1'b1; end
        if (ch == 1 && q_p.size() != 0) begin e = q_p.pop_front(); have = 1'b1; end
        if (!have) begin
            vec_cnt++;
            fail_cnt++;
            $display("[TB] FAIL unexpected_strobe ch%0d: actual dout=%0h required no strobe", ch, dout);
        end else begin
            check_val($sformatf("dout_ch%0d", ch), dout, e.data);
            check_val($sformatf("frame_err_ch%0d", ch), ferr, e.ferr);
            check_val($sformatf("parity_err_ch%0d", ch), perr, e.perr);
            lat = tick_cnt - e.start_tick;
            vec_cnt++;
            if (lat < nom || lat > nom + 3) begin
                fail_cnt++;
                $display("[TB] FAIL latency_ch%0d: actual=%0d required=%0d..%0d", ch, lat, nom, nom + 3);
            end
            last_dout[ch] = e.data;
        end
    endtask

    always @(negedge clk) begin
        if (started && reset_n && bus_n.rx_done_tick)
            checkOutput(0, bus_n.dout, bus_n.frame_err, bus_n.parity_err);
    end

    always @(negedge clk) begin
        if (started && reset_n && bus_p.rx_done_tick)
            checkOutput(1, bus_p.dout, bus_p.frame_err, bus_p.parity_err);
    end

    task automatic check_reset_outputs();
        check_val("rst_dout_n", bus_n.dout, 0);
        check_val("rst_done_n", bus_n.rx_done_tick, 0);
        check_val("rst_ferr_n", bus_n.frame_err, 0);
        check_val("rst_perr_n", bus_n.parity_err, 0);
        check_val("rst_dout_p", bus_p.dout, 0);
        check_val("rst_ferr_p", bus_p.frame_err, 0);
    endtask

    initial begin
        logic [7:0] rdata;
        int         ch;
        #2 reset_n = 1'b0;
        repeat (4) @(negedge clk);
        check_reset_outputs();
        reset_n = 1'b1;
        started = 1'b1;
        last_dout[0] = 8'h00;
        last_dout[1] = 8'h00;
        wait_ticks(20);

        applyStimulus(0, 8'h55, 1'b0, 1'b1, 10);
        drive_rx(0, 1'b0);
        wait_ticks(4);
        drive_rx(0, 1'b1);
        wait_ticks(40);
        check_val("glitch_dout_hold", bus_n.dout, last_dout[0]);
        applyStimulus(0, 8'h00, 1'b0, 1'b0, 10);
        applyStimulus(0, 8'h81, 1'b0, 1'b1, 10);
        applyStimulus(0, 8'h01, 1'b0, 1'b1, 0);
        applyStimulus(0, 8'hFE, 1'b0, 1'b1, 10);

        applyStimulus(1, 8'hA5, 1'b1, 1'b1, 10);
        applyStimulus(1, 8'hA5, 1'b0, 1'b1, 10);

        drive_rx(0, 1'b0);
        wait_ticks(16);
        for (int i = 0; i < 3; i++) begin
            rdata = 8'hC3;
            drive_rx(0, rdata[i]);
            wait_ticks(16);
        end
        drive_rx(0, 1'b0);
        wait_ticks(8);
        reset_n = 1'b0;
        #1;
        check_reset_outputs();
        repeat (3) @(negedge clk);
        rx_n = 1'b1;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        last_dout[0] = 8'h00;
        last_dout[1] = 8'h00;
        wait_ticks(40);
        check_val("post_reset_dout", bus_n.dout, 0);
        applyStimulus(0, 8'h3C, 1'b0, 1'b1, 10);

        for (int k = 0; k < 24; k++) begin
            tick_div = int'($urandom_range(1, 4));
            ch       = int'($urandom_range(0, 1));
            rdata    = 8'($urandom);
            applyStimulus(ch, rdata, 1'($urandom), ($urandom_range(0, 6) != 0), int'($urandom_range(0, 10)));
        end

        tick_div = 4;
        wait_ticks(300);
        check_val("pending_n", q_n.size(), 0);
        check_val("pending_p", q_p.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, fail_cnt);
        $finish;
    end

endmodule
